decode: RTL and testbench

Second stage of the Y86 pipeline, directly downstream of `fetch`. It captures each instruction that `fetch` presents and derives source and destination register IDs from `icode`/`rA`/`rB`. It reads an internal 8×32 register file and resolves operands by forwarding from execute, memory and write-back. It inserts load-use bubbles and presents a registered decoded instruction to execute, with a one-entry holding slot and a branch-mispredict flush.

---
 rtl/y86_pkg.sv | 21 ++
 rtl/y86_regfile.sv | 38 +++
 rtl/decode.sv | 186 ++++++++++++++++++
 tb/tb_decode.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes and special register IDs.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVL = 4'h2;
    localparam logic [3:0] IRMOVL = 4'h3;
    localparam logic [3:0] RMMOVL = 4'h4;
    localparam logic [3:0] MRMOVL = 4'h5;
    localparam logic [3:0] OPL    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHL  = 4'hA;
    localparam logic [3:0] POPL   = 4'hB;

    localparam logic [3:0] REG_ESP      = 4'd4;
    localparam logic [3:0] REG_NONE     = 4'hF;
    localparam logic [3:0] BUBBLE_ICODE = NOP;

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational reads, E and M write ports (M wins).
module y86_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [3:0]    ra_id,
    output logic [DW-1:0] ra_val,
    input  logic [3:0]    rb_id,
    output logic [DW-1:0] rb_val,
    input  logic [3:0]    we_id,
    input  logic [DW-1:0] we_val,
    input  logic [3:0]    wm_id,
    input  logic [DW-1:0] wm_val
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][DW-1:0] regs;

    assign ra_val = (ra_id < 4'(NREG)) ? regs[ra_id[AW-1:0]] : '0;
    assign rb_val = (rb_id < 4'(NREG)) ? regs[rb_id[AW-1:0]] : '0;

    // IDs outside 0..NREG-1 match no entry, so those writes fall away naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wm_id == 4'(i))
                    regs[i] <= wm_val;
                else if (we_id == 4'(i))
                    regs[i] <= we_val;
            end
        end
    end

endmodule

// File: rtl/decode.sv
// Y86 decode stage: one-entry holding slot, register read with forwarding,
// load-use bubble insertion and a registered decoded instruction for execute.
module decode
    import y86_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          f_stall,
    input  logic [3:0]    f_icode,
    input  logic [3:0]    f_ifun,
    input  logic [3:0]    f_rA,
    input  logic [3:0]    f_rB,
    input  logic [DW-1:0] f_valC,
    input  logic [DW-1:0] f_valP,
    input  logic          f_pred,
    output logic          d_busy,
    input  logic          wrong_pred,
    input  logic          e_stall,
    input  logic [3:0]    ex_dstE,
    input  logic [DW-1:0] ex_valE,
    input  logic [3:0]    ex_dstM,
    input  logic [3:0]    mem_dstE,
    input  logic [DW-1:0] mem_valE,
    input  logic [3:0]    mem_dstM,
    input  logic [DW-1:0] mem_valM,
    input  logic [3:0]    wb_dstE,
    input  logic [DW-1:0] wb_valE,
    input  logic [3:0]    wb_dstM,
    input  logic [DW-1:0] wb_valM,
    output logic          d_valid,
    output logic [3:0]    d_icode,
    output logic [3:0]    d_ifun,
    output logic          d_pred,
    output logic [DW-1:0] d_valC,
    output logic [DW-1:0] d_valA,
    output logic [DW-1:0] d_valB,
    output logic [3:0]    d_srcA,
    output logic [3:0]    d_srcB,
    output logic [3:0]    d_dstE,
    output logic [3:0]    d_dstM
);
    typedef struct packed {
        logic [3:0]    icode;
        logic [3:0]    ifun;
        logic [3:0]    rA;
        logic [3:0]    rB;
        logic [DW-1:0] valC;
        logic [DW-1:0] valP;
        logic          pred;
    } slot_t;

    typedef struct packed {
        logic          valid;
        logic [3:0]    icode;
        logic [3:0]    ifun;
        logic          pred;
        logic [DW-1:0] valC;
        logic [DW-1:0] valA;
        logic [DW-1:0] valB;
        logic [3:0]    srcA;
        logic [3:0]    srcB;
        logic [3:0]    dstE;
        logic [3:0]    dstM;
    } out_t;

    localparam out_t BUBBLE = '{valid: 1'b0, icode: BUBBLE_ICODE, ifun: 4'h0, pred: 1'b0,
                                valC: '0, valA: '0, valB: '0, srcA: REG_NONE,
                                srcB: REG_NONE, dstE: REG_NONE, dstM: REG_NONE};

    slot_t         slot_q, f_in;
    logic          slot_full;
    out_t          out_q, dec;
    logic [3:0]    src_a, src_b, dst_e, dst_m;
    logic [DW-1:0] rf_a, rf_b;
    logic          hazard;

    assign f_in = '{icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB,
                    valC: f_valC, valP: f_valP, pred: f_pred};

    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (slot_q.icode)
            RRMOVL: begin src_a = slot_q.rA; dst_e = slot_q.rB; end
            IRMOVL: dst_e = slot_q.rB;
            RMMOVL: begin src_a = slot_q.rA; src_b = slot_q.rB; end
            MRMOVL: begin src_b = slot_q.rB; dst_m = slot_q.rA; end
            OPL:    begin src_a = slot_q.rA; src_b = slot_q.rB; dst_e = slot_q.rB; end
            CALL:   begin src_b = REG_ESP; dst_e = REG_ESP; end
            RET:    begin src_a = REG_ESP; src_b = REG_ESP; dst_e = REG_ESP; end
            PUSHL:  begin src_a = slot_q.rA; src_b = REG_ESP; dst_e = REG_ESP; end
            POPL:   begin src_a = REG_ESP; src_b = REG_ESP; dst_e = REG_ESP; dst_m = slot_q.rA; end
            default: ;
        endcase
    end

    y86_regfile #(.DW(DW), .NREG(NREG)) u_rf (
        .clock   (clock),
        .reset_n (reset_n),
        .ra_id   (src_a),
        .ra_val  (rf_a),
        .rb_id   (src_b),
        .rb_val  (rf_b),
        .we_id   (wb_dstE),
        .we_val  (wb_valE),
        .wm_id   (wb_dstM),
        .wm_val  (wb_valM)
    );

    // Youngest producer wins; the wb ports also cover a same-cycle register write.
    function automatic logic [DW-1:0] fwd(input logic [3:0] r, input logic [DW-1:0] rf_val);
        if (r >= 4'(NREG))   return '0;
        if (r == ex_dstE)    return ex_valE;
        if (r == mem_dstM)   return mem_valM;
        if (r == mem_dstE)   return mem_valE;
        if (r == wb_dstM)    return wb_valM;
        if (r == wb_dstE)    return wb_valE;
        return rf_val;
    endfunction

    always_comb begin
        dec       = BUBBLE;
        dec.valid = 1'b1;
        dec.icode = slot_q.icode;
        dec.ifun  = slot_q.ifun;
        dec.pred  = slot_q.pred;
        dec.valC  = slot_q.valC;
        dec.valA  = (slot_q.icode == CALL || slot_q.icode == JXX) ? slot_q.valP : fwd(src_a, rf_a);
        dec.valB  = fwd(src_b, rf_b);
        dec.srcA  = src_a;
        dec.srcB  = src_b;
        dec.dstE  = dst_e;
        dec.dstM  = dst_m;
    end

    assign hazard = slot_full && (ex_dstM != REG_NONE) &&
                    (ex_dstM == src_a || ex_dstM == src_b);
    assign d_busy = slot_full && (hazard || e_stall);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_full <= 1'b0;
            slot_q    <= '0;
            out_q     <= BUBBLE;
        end else if (wrong_pred) begin
            slot_full <= 1'b0;
            out_q     <= BUBBLE;
        end else if (e_stall) begin
            if (!slot_full && !f_stall) begin
                slot_q    <= f_in;
                slot_full <= 1'b1;
            end
        end else if (hazard) begin
            out_q <= BUBBLE;
        end else if (slot_full) begin
            out_q     <= dec;
            slot_full <= !f_stall;
            if (!f_stall)
                slot_q <= f_in;
        end else begin
            out_q <= BUBBLE;
            if (!f_stall) begin
                slot_q    <= f_in;
                slot_full <= 1'b1;
            end
        end
    end

    assign d_valid = out_q.valid;
    assign d_icode = out_q.icode;
    assign d_ifun  = out_q.ifun;
    assign d_pred  = out_q.pred;
    assign d_valC  = out_q.valC;
    assign d_valA  = out_q.valA;
    assign d_valB  = out_q.valB;
    assign d_srcA  = out_q.srcA;
    assign d_srcB  = out_q.srcB;
    assign d_dstE  = out_q.dstE;
    assign d_dstM  = out_q.dstM;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: expected decodes are queued at issue and popped on each new valid output.
module tb_decode;
    import y86_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_stall, f_pred, wrong_pred, e_stall;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [31:0] f_valC, f_valP;
    logic [3:0]  ex_dstE, ex_dstM, mem_dstE, mem_dstM, wb_dstE, wb_dstM;
    logic [31:0] ex_valE, mem_valE, mem_valM, wb_valE, wb_valM;
    logic        d_busy, d_valid, d_pred;
    logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
    logic [31:0] d_valC, d_valA, d_valB;

    typedef struct {
        logic [3:0]  icode, ifun, srcA, srcB, dstE, dstM;
        logic [31:0] valA, valB, valC;
        logic        pred;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    logic [31:0] rf_m [8];
    logic        stall_q = 1'b0;
    int          n_chk = 0;
    int          n_bad = 0;

    decode dut (
        .clock(clock), .reset_n(reset_n), .f_stall(f_stall), .f_icode(f_icode),
        .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .f_pred(f_pred), .d_busy(d_busy), .wrong_pred(wrong_pred), .e_stall(e_stall),
        .ex_dstE(ex_dstE), .ex_valE(ex_valE), .ex_dstM(ex_dstM),
        .mem_dstE(mem_dstE), .mem_valE(mem_valE), .mem_dstM(mem_dstM), .mem_valM(mem_valM),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_pred(d_pred),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .d_srcA(d_srcA),
        .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] fwd_m(input logic [3:0] r);
        if (r[3])            return 32'h0;
        if (r == ex_dstE)    return ex_valE;
        if (r == mem_dstM)   return mem_valM;
        if (r == mem_dstE)   return mem_valE;
        if (r == wb_dstM)    return wb_valM;
        if (r == wb_dstE)    return wb_valE;
        return rf_m[r[2:0]];
    endfunction

    function automatic exp_t model(input logic [3:0] ic, fn, ra, rb,
                                   input logic [31:0] vc, vp, input logic pr);
        exp_t e;
        logic [15:0] ids;   // {srcA, srcB, dstE, dstM}
        case (ic)
            4'h2:    ids = {ra,   4'hF, rb,   4'hF};
            4'h3:    ids = {4'hF, 4'hF, rb,   4'hF};
            4'h4:    ids = {ra,   rb,   4'hF, 4'hF};
            4'h5:    ids = {4'hF, rb,   4'hF, ra};
            4'h6:    ids = {ra,   rb,   rb,   4'hF};
            4'h8:    ids = {4'hF, 4'h4, 4'h4, 4'hF};
            4'h9:    ids = {4'h4, 4'h4, 4'h4, 4'hF};
            4'hA:    ids = {ra,   4'h4, 4'h4, 4'hF};
            4'hB:    ids = {4'h4, 4'h4, 4'h4, ra};
            default: ids = 16'hFFFF;
        endcase
        e.icode = ic;  e.ifun = fn;  e.valC = vc;  e.pred = pr;
        e.srcA = ids[15:12];  e.srcB = ids[11:8];  e.dstE = ids[7:4];  e.dstM = ids[3:0];
        e.valA = (ic == 4'h7 || ic == 4'h8) ? vp : fwd_m(e.srcA);
        e.valB = fwd_m(e.srcB);
        return e;
    endfunction

    task automatic drive_f(input logic [3:0] ic, fn, ra, rb, input logic [31:0] vc, vp,
                           input logic pr);
        f_icode = ic;  f_ifun = fn;  f_rA = ra;  f_rB = rb;
        f_valC = vc;   f_valP = vp;  f_pred = pr;  f_stall = 1'b0;
    endtask

    task automatic set_wb(input logic [3:0] de, input logic [31:0] ve,
                          input logic [3:0] dm, input logic [31:0] vm);
        wb_dstE = de;  wb_valE = ve;  wb_dstM = dm;  wb_valM = vm;
        if (!de[3]) rf_m[de[2:0]] = ve;
        if (!dm[3]) rf_m[dm[2:0]] = vm;
    endtask

    task automatic clr_fwd();
        ex_dstE = 4'hF;  ex_valE = 0;  ex_dstM = 4'hF;
        mem_dstE = 4'hF; mem_valE = 0; mem_dstM = 4'hF; mem_valM = 0;
        wb_dstE = 4'hF;  wb_valE = 0;  wb_dstM = 4'hF;  wb_valM = 0;
    endtask

    // Issue one instruction, wait through its evaluation cycle and one spare cycle.
    task automatic send(input logic [3:0] ic, fn, ra, rb, input logic [31:0] vc, vp,
                        input logic pr);
        @(posedge clock); #1;
        drive_f(ic, fn, ra, rb, vc, vp, pr);
        sb.push_back(model(ic, fn, ra, rb, vc, vp, pr));
        @(posedge clock); #1;
        f_stall = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(d_valid), 32'd0);
        chk({tag, "_icode"}, 32'(d_icode), 32'(BUBBLE_ICODE));
        chk({tag, "_srcA"},  32'(d_srcA),  32'hF);
    endtask

    always @(posedge clock) stall_q <= e_stall;

    always @(negedge clock) begin
        if (reset_n && d_valid && !stall_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(d_icode), 32'hFFFF_FFFF);
            end else begin
                got = sb.pop_front();
                chk("icode", 32'(d_icode), 32'(got.icode));
                chk("ifun",  32'(d_ifun),  32'(got.ifun));
                chk("srcA",  32'(d_srcA),  32'(got.srcA));
                chk("srcB",  32'(d_srcB),  32'(got.srcB));
                chk("dstE",  32'(d_dstE),  32'(got.dstE));
                chk("dstM",  32'(d_dstM),  32'(got.dstM));
                chk("valA",  d_valA,       got.valA);
                chk("valB",  d_valB,       got.valB);
                chk("valC",  d_valC,       got.valC);
                chk("pred",  32'(d_pred),  32'(got.pred));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;  f_stall = 1'b1;  wrong_pred = 1'b0;  e_stall = 1'b0;
        drive_f(4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 1'b0);
        f_stall = 1'b1;
        clr_fwd();
        for (int i = 0; i < 8; i++) rf_m[i] = 0;

        @(negedge clock);
        chk_bubble("rst");
        chk("rst_pred", 32'(d_pred), 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // irmovl writes reg2 through wb, then rrmovl 2->3 reads it
        set_wb(4'd2, 32'h55, 4'hF, 0);
        send(IRMOVL, 4'h0, 4'hF, 4'd2, 32'h55, 32'h6, 1'b0);
        clr_fwd();
        send(RRMOVL, 4'h0, 4'd2, 4'd3, 0, 32'h8, 1'b0);

        // ex forward beats a same-cycle wb write of the same register
        ex_dstE = 4'd1;  ex_valE = 32'hAA;
        set_wb(4'd1, 32'h11, 4'hF, 0);
        send(OPL, 4'h0, 4'd1, 4'd5, 0, 32'hA, 1'b0);
        clr_fwd();
        mem_dstE = 4'd2;  mem_valE = 32'h77;
        send(OPL, 4'h1, 4'd1, 4'd2, 0, 32'hC, 1'b0);
        clr_fwd();

        // load-use: mrmovl to reg0 sits in execute while OPl reading reg0 waits
        @(posedge clock); #1;
        drive_f(OPL, 4'h0, 4'd0, 4'd3, 0, 32'hE, 1'b0);
        ex_dstM = 4'd0;
        @(posedge clock); #1;
        f_stall = 1'b1;
        @(negedge clock);
        chk("lu_busy", 32'(d_busy), 32'd1);
        @(posedge clock); #1;
        ex_dstM = 4'hF;  mem_dstM = 4'd0;  mem_valM = 32'h99;
        sb.push_back(model(OPL, 4'h0, 4'd0, 4'd3, 0, 32'hE, 1'b0));
        @(negedge clock);
        chk_bubble("lu_bub");
        chk("lu_busy_clr", 32'(d_busy), 32'd0);
        @(posedge clock); #1;
        clr_fwd();

        // stack ops, control flow, invalid register ID, halt
        set_wb(4'd6, 32'h66, 4'd4, 32'h100);
        @(posedge clock); #1;
        clr_fwd();
        send(PUSHL, 4'h0, 4'd6, 4'hF, 0, 32'h20, 1'b0);
        send(CALL,  4'h0, 4'hF, 4'hF, 32'h80, 32'h40, 1'b0);
        send(POPL,  4'h0, 4'd7, 4'hF, 0, 32'h42, 1'b0);
        send(RET,   4'h0, 4'hF, 4'hF, 0, 32'h44, 1'b0);
        send(JXX,   4'h3, 4'hF, 4'hF, 32'h200, 32'h123, 1'b1);
        send(MRMOVL, 4'h0, 4'd0, 4'd6, 32'h10, 32'h50, 1'b0);
        send(RMMOVL, 4'h0, 4'd2, 4'd1, 32'h14, 32'h56, 1'b0);
        send(RRMOVL, 4'h0, 4'd9, 4'd5, 0, 32'h5C, 1'b0);
        send(HALT,  4'h0, 4'hF, 4'hF, 0, 32'h5E, 1'b0);

        // flush in the same cycle fetch presents: instruction dropped
        @(posedge clock); #1;
        drive_f(OPL, 4'h0, 4'd1, 4'd2, 0, 32'h60, 1'b0);
        wrong_pred = 1'b1;
        @(posedge clock); #1;
        f_stall = 1'b1;  wrong_pred = 1'b0;
        @(negedge clock);
        chk("wp_busy", 32'(d_busy), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk_bubble("wp_drop");

        // flush a full slot
        @(posedge clock); #1;
        drive_f(RRMOVL, 4'h0, 4'd1, 4'd2, 0, 32'h62, 1'b0);
        @(posedge clock); #1;
        f_stall = 1'b1;  wrong_pred = 1'b1;
        @(posedge clock); #1;
        wrong_pred = 1'b0;
        @(negedge clock);
        chk_bubble("wp_slot");
        @(posedge clock); #1;
        @(negedge clock);
        chk("wp_empty", 32'(d_valid), 32'd0);

        // execute stall: slot waits, then output holds while stalled
        @(posedge clock); #1;
        drive_f(OPL, 4'h2, 4'd2, 4'd1, 0, 32'h70, 1'b0);
        sb.push_back(model(OPL, 4'h2, 4'd2, 4'd1, 0, 32'h70, 1'b0));
        @(posedge clock); #1;
        f_stall = 1'b1;  e_stall = 1'b1;
        @(negedge clock);
        chk("es_busy", 32'(d_busy), 32'd1);
        @(posedge clock); #1;
        e_stall = 1'b0;
        @(negedge clock);
        chk("es_hold_bub", 32'(d_valid), 32'd0);
        chk("es_busy_clr", 32'(d_busy), 32'd0);
        @(posedge clock); #1;
        e_stall = 1'b1;
        @(posedge clock); #1;
        e_stall = 1'b0;
        @(negedge clock);
        chk("es_hold_vld", 32'(d_valid), 32'd1);
        chk("es_hold_ic",  32'(d_icode), 32'(OPL));
        @(posedge clock); #1;
        @(negedge clock);
        chk("es_after", 32'(d_valid), 32'd0);

        // simultaneous wb E/M to reg4: M value wins
        @(posedge clock); #1;
        set_wb(4'd4, 32'h1, 4'd4, 32'h2);
        @(posedge clock); #1;
        clr_fwd();
        send(RRMOVL, 4'h0, 4'd4, 4'd3, 0, 32'h80, 1'b0);

        // reset mid-stream with a pending slot and an active wb write
        @(posedge clock); #1;
        drive_f(RRMOVL, 4'h0, 4'd4, 4'd0, 0, 32'h90, 1'b0);
        @(posedge clock); #1;
        f_stall = 1'b1;
        wb_dstE = 4'd5;  wb_valE = 32'h7;
        reset_n = 1'b0;
        @(negedge clock);
        chk_bubble("mid_rst");
        chk("mid_rst_pred", 32'(d_pred), 32'd0);
        @(posedge clock); #1;
        clr_fwd();
        for (int i = 0; i < 8; i++) rf_m[i] = 0;
        reset_n = 1'b1;
        @(negedge clock);
        chk("mid_rst_valid", 32'(d_valid), 32'd0);
        send(RRMOVL, 4'h0, 4'd4, 4'd1, 0, 32'hA0, 1'b0);
        send(RRMOVL, 4'h0, 4'd5, 4'd1, 0, 32'hA2, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
